// File: rtl/mem_stage_ld.sv
// MEM pipeline stage: latches EX results, waits for in-order load responses, aligns/extends load data.
// Optional macro MS_PERF_CNT_EN enables the WAIT-cycle counter on ms_ld_stall_cnt.
module mem_stage_ld #(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic [31:0] es_alu_result,
    input  logic        es_mem_req,
    input  logic [2:0]  es_ld_op,
    input  logic        es_excp,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        flush,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_excp,
    output logic [31:0] ms_final_result,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic        ms_fwd_stall,
    output logic [31:0] ms_ld_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ms_valid;
    logic [CANCEL_W-1:0] r_cancel_cnt;
    logic [31:0]         r_buf;
    logic [31:0]         r_pc;
    logic [4:0]          r_dest;
    logic                r_gr_we;
    logic [31:0]         r_alu_result;
    logic [2:0]          r_ld_op;
    logic                r_excp;

    logic                w_cancel_zero;
    logic                w_data_live;
    logic                w_in_wait;
    logic                w_ready_go;
    logic                w_accept;
    logic                w_leave;
    logic                w_need_wait;
    logic                w_cancel_inc;
    logic                w_cancel_dec;
    logic                w_capture;
    logic [31:0]         w_raw;

    function automatic logic [31:0] f_load_align(input logic [2:0]  op,
                                                 input logic [1:0]  addr,
                                                 input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[8*addr +: 8];
        h = addr[1] ? raw[31:16] : raw[15:0];
        case (op)
            3'b001:  f_load_align = {{24{b[7]}}, b};
            3'b010:  f_load_align = {{16{h[15]}}, h};
            3'b101:  f_load_align = {24'd0, b};
            3'b110:  f_load_align = {16'd0, h};
            default: f_load_align = raw;
        endcase
    endfunction

    // A response only belongs to the current instruction once all cancelled ones have drained.
    assign w_cancel_zero = (r_cancel_cnt == '0);
    assign w_data_live   = data_sram_data_ok & w_cancel_zero;
    assign w_in_wait     = (r_state == S_WAIT);
    assign w_ready_go    = !w_in_wait | w_data_live;
    assign ms_allowin    = !r_ms_valid | (w_ready_go & ws_allowin);
    assign w_accept      = es_to_ms_valid & ms_allowin & ~flush;
    assign w_leave       = r_ms_valid & w_ready_go & ws_allowin;
    assign w_need_wait   = es_mem_req & ~es_excp;
    assign w_cancel_inc  = flush & r_ms_valid & w_in_wait & ~w_data_live;
    assign w_cancel_dec  = data_sram_data_ok & ~w_cancel_zero;
    assign w_capture     = r_ms_valid & w_in_wait & w_data_live & ~ws_allowin & ~flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_need_wait ? S_WAIT : S_IDLE;
        end else if (w_leave) begin
            w_state_nxt = S_IDLE;
        end else if (w_capture) begin
            w_state_nxt = S_HELD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ms_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cancel_cnt <= '0;
        end else begin
            case ({w_cancel_inc, w_cancel_dec})
                2'b10:   r_cancel_cnt <= r_cancel_cnt + CANCEL_W'(1);
                2'b01:   r_cancel_cnt <= r_cancel_cnt - CANCEL_W'(1);
                default: r_cancel_cnt <= r_cancel_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= '0;
            r_dest       <= '0;
            r_gr_we      <= 1'b0;
            r_alu_result <= '0;
            r_ld_op      <= '0;
            r_excp       <= 1'b0;
            r_buf        <= '0;
        end else begin
            if (w_accept) begin
                r_pc         <= es_pc;
                r_dest       <= es_dest;
                r_gr_we      <= es_gr_we;
                r_alu_result <= es_alu_result;
                r_ld_op      <= es_ld_op;
                r_excp       <= es_excp;
            end
            if (w_capture) begin
                r_buf <= data_sram_rdata;
            end
        end
    end

    // EX must never issue more cancelled loads than the counter can hold.
    assert property (@(posedge clk) disable iff (!reset)
        !(w_cancel_inc && !w_cancel_dec && (&r_cancel_cnt)));

    assign w_raw           = (r_state == S_HELD) ? r_buf : data_sram_rdata;
    assign ms_final_result = (r_ld_op == 3'b000) ? r_alu_result
                                                 : f_load_align(r_ld_op, r_alu_result[1:0], w_raw);
    assign ms_to_ws_valid  = r_ms_valid & w_ready_go & ~flush;
    assign ms_pc           = r_pc;
    assign ms_dest         = r_dest;
    assign ms_gr_we        = r_gr_we;
    assign ms_excp         = r_excp;
    assign ms_fwd_valid    = r_ms_valid & r_gr_we;
    assign ms_fwd_dest     = r_dest;
    assign ms_fwd_stall    = r_ms_valid & w_in_wait & ~w_data_live;

`ifdef MS_PERF_CNT_EN
    logic [31:0] r_ld_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_stall_cnt <= '0;
        end else if (r_ms_valid & w_in_wait) begin
            r_ld_stall_cnt <= r_ld_stall_cnt + 32'd1;
        end
    end

    assign ms_ld_stall_cnt = r_ld_stall_cnt;
`else
    assign ms_ld_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ld.sv
// Bench for mem_stage_ld: directed literal cases, then random traffic against a slot/response-queue model.
module tb_mem_stage_ld;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [31:0] es_alu_result;
    logic        es_mem_req;
    logic [2:0]  es_ld_op;
    logic        es_excp;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_excp;
    logic [31:0] ms_final_result;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic        ms_fwd_stall;
    logic [31:0] ms_ld_stall_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    mem_stage_ld #(.CANCEL_W(2)) dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_alu_result(es_alu_result), .es_mem_req(es_mem_req),
        .es_ld_op(es_ld_op), .es_excp(es_excp),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_dest(ms_dest),
        .ms_gr_we(ms_gr_we), .ms_excp(ms_excp), .ms_final_result(ms_final_result),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
        .ms_fwd_stall(ms_fwd_stall), .ms_ld_stall_cnt(ms_ld_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid = 0; es_pc = 0; es_dest = 0; es_gr_we = 0; es_alu_result = 0;
        es_mem_req = 0; es_ld_op = 0; es_excp = 0; data_sram_data_ok = 0;
        data_sram_rdata = 0; flush = 0; ws_allowin = 1;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic accept_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] pc);
        es_to_ms_valid = 1; es_mem_req = 1; es_ld_op = op; es_alu_result = addr;
        es_pc = pc; es_dest = 5'd7; es_gr_we = 1;
        tick();
        es_to_ms_valid = 0; es_mem_req = 0;
    endtask

    // Reference load alignment expressed with shifts and masks.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        logic [1:0]  a;
        a = addr[1:0];
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'b000:  return addr;
            3'b001:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'b010:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'b101:  return b;
            3'b110:  return h;
            default: return w;
        endcase
    endfunction

    task automatic ld_case(input logic [2:0] op, input logic [1:0] a, input logic [31:0] exp);
        accept_load(op, 32'h0000_1000 | {30'd0, a}, 32'h200);
        chk("ld_stall_wait", ms_fwd_stall, 1);
        chk("ld_no_valid_wait", ms_to_ws_valid, 0);
        tick();
        chk("ld_stall_wait2", ms_fwd_stall, 1);
        tick();
        data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_0000;
        #1;
        chk("ld_stall_clear", ms_fwd_stall, 0);
        chk("ld_valid", ms_to_ws_valid, 1);
        chk("ld_result", ms_final_result, exp);
        tick();
        data_sram_data_ok = 0;
        #1;
        chk("ld_left", ms_to_ws_valid, 0);
    endtask

    // Model state: the instruction in the stage plus the queue of responses still owed (1 = cancelled).
    logic        m_valid, m_we, m_excp, m_wait, m_has;
    logic [31:0] m_pc, m_alu, m_data, m_perf;
    logic [4:0]  m_dest;
    logic [2:0]  m_op;
    bit          q[$];

    localparam logic [2:0] OPS [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};

    initial begin
        int n_drop;
        logic d_live, ready, e_allow, accept;

        idle_inputs();
        reset = 0;
        #1;
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_to_ws", ms_to_ws_valid, 0);
        chk("rst_result", ms_final_result, 0);
        chk("rst_stall", ms_fwd_stall, 0);
        chk("rst_fwd_valid", ms_fwd_valid, 0);
        chk("rst_perf", ms_ld_stall_cnt, 0);
        tick();
        tick();
        reset = 1;

        // ALU op passes straight through.
        es_to_ms_valid = 1; es_alu_result = 32'h1234_5678; es_pc = 32'h1000;
        es_dest = 5'd5; es_gr_we = 1;
        tick();
        es_to_ms_valid = 0;
        #1;
        chk("alu_valid", ms_to_ws_valid, 1);
        chk("alu_result", ms_final_result, 32'h1234_5678);
        chk("alu_pc", ms_pc, 32'h1000);
        chk("alu_fwd", {ms_fwd_valid, 26'd0, ms_fwd_dest}, {1'b1, 26'd0, 5'd5});
        chk("alu_stall", ms_fwd_stall, 0);
        tick();
        chk("alu_left", ms_to_ws_valid, 0);

        ld_case(3'b001, 2'd3, 32'hFFFF_FF80);
        ld_case(3'b101, 2'd3, 32'h0000_0080);
        ld_case(3'b010, 2'd2, 32'hFFFF_80FF);
        ld_case(3'b110, 2'd2, 32'h0000_80FF);
        ld_case(3'b011, 2'd0, 32'h80FF_0000);
        ld_case(3'b001, 2'd2, 32'hFFFF_FFFF);

        // Response arrives while WB stalls: held data must survive rdata changing.
        accept_load(3'b011, 32'h0, 32'h300);
        data_sram_data_ok = 1; data_sram_rdata = 32'h1122_3344; ws_allowin = 0;
        #1;
        chk("held_valid0", ms_to_ws_valid, 1);
        chk("held_allowin0", ms_allowin, 0);
        tick();
        data_sram_data_ok = 0; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("held_result", ms_final_result, 32'h1122_3344);
        chk("held_stall", ms_fwd_stall, 0);
        tick();
        ws_allowin = 1;
        #1;
        chk("held_deliver", ms_final_result, 32'h1122_3344);
        chk("held_allowin", ms_allowin, 1);
        tick();
        chk("held_left", ms_to_ws_valid, 0);

        // Flush during WAIT: the stale response is dropped, the next one delivered.
        accept_load(3'b011, 32'h0, 32'h400);
        flush = 1;
        #1;
        chk("flush_to_ws", ms_to_ws_valid, 0);
        tick();
        flush = 0;
        accept_load(3'b011, 32'h0, 32'h404);
        data_sram_data_ok = 1; data_sram_rdata = 32'hAAAA_AAAA;
        #1;
        chk("cancel_drop", ms_to_ws_valid, 0);
        chk("cancel_stall", ms_fwd_stall, 1);
        tick();
        data_sram_rdata = 32'h5555_5555;
        #1;
        chk("cancel_next_valid", ms_to_ws_valid, 1);
        chk("cancel_next_result", ms_final_result, 32'h5555_5555);
        chk("cancel_next_pc", ms_pc, 32'h404);
        tick();
        data_sram_data_ok = 0;

        // Flush and response in the same cycle: no cancel is left behind.
        accept_load(3'b011, 32'h0, 32'h500);
        data_sram_data_ok = 1; flush = 1; data_sram_rdata = 32'h7777_7777;
        #1;
        chk("flush_ok_to_ws", ms_to_ws_valid, 0);
        tick();
        data_sram_data_ok = 0; flush = 0;
        accept_load(3'b011, 32'h0, 32'h504);
        data_sram_data_ok = 1; data_sram_rdata = 32'h0BAD_F00D;
        #1;
        chk("flush_ok_next", ms_to_ws_valid, 1);
        chk("flush_ok_result", ms_final_result, 32'h0BAD_F00D);
        tick();
        data_sram_data_ok = 0;

        // Exception instruction never waits.
        es_to_ms_valid = 1; es_mem_req = 1; es_ld_op = 3'b011; es_excp = 1; es_pc = 32'h600;
        tick();
        es_to_ms_valid = 0; es_mem_req = 0; es_excp = 0;
        #1;
        chk("excp_valid", ms_to_ws_valid, 1);
        chk("excp_flag", ms_excp, 1);
        chk("excp_stall", ms_fwd_stall, 0);
        tick();

        // Asynchronous reset in the middle of WAIT.
        accept_load(3'b011, 32'h0, 32'h700);
        #2;
        reset = 0;
        #1;
        chk("arst_valid", ms_to_ws_valid, 0);
        chk("arst_allowin", ms_allowin, 1);
        chk("arst_stall", ms_fwd_stall, 0);
        chk("arst_pc", ms_pc, 0);
        tick();
        reset = 1;
        accept_load(3'b011, 32'h0, 32'h704);
        data_sram_data_ok = 1; data_sram_rdata = 32'h0F0F_0F0F;
        #1;
        chk("arst_next_valid", ms_to_ws_valid, 1);
        chk("arst_next_result", ms_final_result, 32'h0F0F_0F0F);
        tick();
        idle_inputs();

        // Random traffic against the behavioural model.
        do_reset();
        m_valid = 0; m_we = 0; m_excp = 0; m_wait = 0; m_has = 0;
        m_pc = 0; m_alu = 0; m_data = 0; m_dest = 0; m_op = 0; m_perf = 0;
        q.delete();
        for (int i = 0; i < 3000; i++) begin
            n_drop = 0;
            foreach (q[k]) if (q[k]) n_drop++;
            es_to_ms_valid    = ($urandom % 2) == 0;
            es_pc             = $urandom;
            es_dest           = 5'($urandom);
            es_gr_we          = ($urandom % 4) != 0;
            es_alu_result     = $urandom;
            es_ld_op          = OPS[$urandom % 6];
            es_mem_req        = (es_ld_op != 3'b000);
            es_excp           = ($urandom % 8) == 0;
            data_sram_data_ok = (q.size() > 0) && (($urandom % 3) == 0);
            data_sram_rdata   = $urandom;
            flush             = (($urandom % 12) == 0) && (n_drop < 2);
            ws_allowin        = ($urandom % 4) != 0;
            #1;

            d_live  = data_sram_data_ok && (q.size() > 0) && (q[0] == 1'b0);
            ready   = m_valid && (!m_wait || d_live);
            e_allow = !m_valid || (ready && ws_allowin);
            chk("rnd_to_ws", ms_to_ws_valid, ready && !flush);
            chk("rnd_allowin", ms_allowin, e_allow);
            chk("rnd_stall", ms_fwd_stall, m_valid && m_wait && !d_live);
            chk("rnd_fwd_valid", ms_fwd_valid, m_valid && m_we);
            if (m_valid) begin
                chk("rnd_pc", ms_pc, m_pc);
                chk("rnd_dest", {ms_fwd_dest, ms_dest}, {m_dest, m_dest});
                chk("rnd_excp", {ms_gr_we, ms_excp}, {m_we, m_excp});
            end
            if (ready && !m_excp)
                chk("rnd_result", ms_final_result,
                    ref_load(m_op, m_alu, m_has ? m_data : data_sram_rdata));
`ifdef MS_PERF_CNT_EN
            chk("rnd_perf", ms_ld_stall_cnt, m_perf);
            if (m_valid && m_wait) m_perf = m_perf + 1;
`else
            chk("rnd_perf", ms_ld_stall_cnt, 0);
`endif

            accept = es_to_ms_valid && e_allow && !flush;
            if (data_sram_data_ok) void'(q.pop_front());
            if (flush) begin
                if (m_valid && m_wait && !d_live) q[q.size() - 1] = 1'b1;
                m_valid = 0; m_wait = 0; m_has = 0;
            end else if (accept) begin
                m_valid = 1; m_pc = es_pc; m_dest = es_dest; m_we = es_gr_we;
                m_alu = es_alu_result; m_op = es_ld_op; m_excp = es_excp;
                m_wait = es_mem_req && !es_excp; m_has = 0;
                if (m_wait) q.push_back(1'b0);
            end else if (ready && ws_allowin) begin
                m_valid = 0; m_wait = 0; m_has = 0;
            end else if (m_valid && d_live) begin
                m_wait = 0; m_has = 1; m_data = data_sram_rdata;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
